// File: rtl/memory_arbiter.sv
// memory_arbiter: arbitrates instruction fetch and data read/write onto a single-ported RAM,
// holds each transaction until ram_ready, returns one-cycle hit pulses and flags a stuck RAM.
module memory_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        ram_ren,
    output logic        ram_wen,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_store,
    input  logic [31:0] ram_load,
    input  logic        ram_ready,
    output logic        bus_err
);
    localparam int CW = ($clog2(TIMEOUT + 1) < 8) ? 8 : $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, IFETCH, DREAD, DWRITE, RESP} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [31:0] r_addr, r_store, r_iload, r_dload;
    logic r_ren, r_wen, r_ihit, r_dhit, r_berr;
    logic w_access, w_timeout, w_issue;
    logic w_ren_n, w_wen_n, w_ihit_n, w_dhit_n;

    assign w_access  = r_state inside {IFETCH, DREAD, DWRITE};
    assign w_timeout = w_access && !ram_ready && r_cnt == CW'(TIMEOUT - 1);
    assign w_issue   = r_state == IDLE && w_next != IDLE;

    always_ff @(posedge CLK) begin
        r_state <= RST ? IDLE : w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = dmemWEN ? DWRITE : dmemREN ? DREAD : imemREN ? IFETCH : IDLE;
            RESP:    w_next = IDLE;
            default: w_next = ram_ready ? RESP : w_timeout ? IDLE : r_state;
        endcase
    end

    // Outputs are decoded from the next state and registered, so nothing reaches a port combinationally.
    always_comb begin
        w_ren_n  = w_next == IFETCH || w_next == DREAD;
        w_wen_n  = w_next == DWRITE;
        w_ihit_n = w_next == RESP && r_state == IFETCH;
        w_dhit_n = w_next == RESP && (r_state == DREAD || r_state == DWRITE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_ihit  <= 1'b0;
            r_dhit  <= 1'b0;
            r_berr  <= 1'b0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_store <= '0;
            r_iload <= '0;
            r_dload <= '0;
        end else begin
            r_ren  <= w_ren_n;
            r_wen  <= w_wen_n;
            r_ihit <= w_ihit_n;
            r_dhit <= w_dhit_n;
            r_cnt  <= !w_access ? '0 : !ram_ready ? r_cnt + 1'b1 : r_cnt;
            if (w_issue) begin
                r_addr <= (dmemWEN || dmemREN) ? dmemaddr : imemaddr;
                if (dmemWEN) r_store <= dmemstore;
            end
            if (ram_ready && r_state == IFETCH) r_iload <= ram_load;
            if (ram_ready && r_state == DREAD) r_dload <= ram_load;
            if (w_timeout) r_berr <= 1'b1;
        end
    end

    assign ram_ren   = r_ren;
    assign ram_wen   = r_wen;
    assign ram_addr  = r_addr;
    assign ram_store = r_store;
    assign ihit      = r_ihit;
    assign dhit      = r_dhit;
    assign imemload  = r_iload;
    assign dmemload  = r_dload;
    assign bus_err   = r_berr;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard bench for memory_arbiter; a second instance with TIMEOUT=4
// exercises the watchdog.
module tb_memory_arbiter;
    logic clk = 0;
    logic rst = 1;
    logic ireq = 1, dren = 1, dwen = 1;
    logic [31:0] iaddr = 0, daddr = 0, dstore = 0, rload = 0;
    logic rdy = 0, s_en = 1;
    logic s_rdy;
    logic ihit, dhit, ren, wen, berr;
    logic [31:0] iload, dload, addr, store;
    logic s_ihit, s_dhit, s_ren, s_wen, s_berr;
    logic [31:0] s_iload, s_dload, s_addr, s_store;

    typedef struct packed {
        logic d;
        logic [31:0] data;
    } exp_t;
    exp_t q[$];
    exp_t m_e;
    logic [31:0] m_dload = 0, m_store = 0;
    int n_checks = 0, n_fail = 0;
    int cyc = 0, t_i = 0, t_d = 0;

    assign s_rdy = rdy & s_en;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    memory_arbiter u_dut (
        .CLK(clk), .RST(rst), .imemREN(ireq), .imemaddr(iaddr), .dmemREN(dren), .dmemWEN(dwen),
        .dmemaddr(daddr), .dmemstore(dstore), .ihit(ihit), .imemload(iload), .dhit(dhit),
        .dmemload(dload), .ram_ren(ren), .ram_wen(wen), .ram_addr(addr), .ram_store(store),
        .ram_load(rload), .ram_ready(rdy), .bus_err(berr)
    );

    memory_arbiter #(.TIMEOUT(4)) u_dut_to (
        .CLK(clk), .RST(rst), .imemREN(ireq), .imemaddr(iaddr), .dmemREN(dren), .dmemWEN(dwen),
        .dmemaddr(daddr), .dmemstore(dstore), .ihit(s_ihit), .imemload(s_iload), .dhit(s_dhit),
        .dmemload(s_dload), .ram_ren(s_ren), .ram_wen(s_wen), .ram_addr(s_addr), .ram_store(s_store),
        .ram_load(rload), .ram_ready(s_rdy), .bus_err(s_berr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Hit monitor: every hit pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (ihit || dhit) begin
            check("hit_excl", 32'(ihit & dhit), 0);
            if (q.size() == 0) check("hit_unexp", {30'b0, ihit, dhit}, 0);
            else begin
                m_e = q.pop_front();
                check("hit_kind", 32'(dhit), 32'(m_e.d));
                check(m_e.d ? "dmemload" : "imemload", m_e.d ? dload : iload, m_e.data);
                if (dhit) t_d = cyc;
                else t_i = cyc;
            end
        end
    end

    // Serve one issued transaction: check held strobes for n cycles, ack in cycle n, check RESP.
    task automatic access(input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                          input int n, input logic [31:0] data);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            check("ram_ren", 32'(ren), 32'(e_ren));
            check("ram_wen", 32'(wen), 32'(e_wen));
            check("ram_addr", addr, e_addr);
            check("ram_store", store, m_store);
            if (k == n) begin
                rdy = 1;
                rload = data;
            end
        end
        @(posedge clk);
        #1 rdy = 0;
        @(negedge clk);
        check("strobe_resp", {30'b0, ren, wen}, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with all requests high
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ren", 32'(ren), 0);
        check("rst_wen", 32'(wen), 0);
        check("rst_hits", {30'b0, ihit, dhit}, 0);
        check("rst_addr", addr, 0);
        check("rst_store", store, 0);
        check("rst_iload", iload, 0);
        check("rst_dload", dload, 0);
        check("rst_berr", 32'(berr), 0);
        // fetch issues right after release
        @(posedge clk);
        #1 rst = 0; dren = 0; dwen = 0; iaddr = 32'h40;
        q.push_back('{d: 0, data: 32'h8C220004});
        @(posedge clk);
        #1 ireq = 0;
        access(1, 0, 32'h40, 3, 32'h8C220004);
        // data read beats a simultaneous fetch
        ireq = 1; dren = 1; iaddr = 32'h44; daddr = 32'h100;
        q.push_back('{d: 1, data: 32'hDEADBEEF});
        m_dload = 32'hDEADBEEF;
        q.push_back('{d: 0, data: 32'h11112222});
        @(posedge clk);
        #1 dren = 0;
        access(1, 0, 32'h100, 1, 32'hDEADBEEF);
        @(posedge clk);
        #1 ireq = 0;
        access(1, 0, 32'h44, 1, 32'h11112222);
        check("i_after_d", 32'(t_i - t_d >= 3), 1);
        // write abandoned by requester still completes
        dwen = 1; daddr = 32'h200; dstore = 32'h12345678;
        m_store = 32'h12345678;
        q.push_back('{d: 1, data: m_dload});
        @(posedge clk);
        #1 dwen = 0; dstore = 0;
        access(0, 1, 32'h200, 5, 32'hFFFF0000);
        // read+write together is a write
        dwen = 1; dren = 1; daddr = 32'h300; dstore = 32'hA5A5A5A5;
        m_store = 32'hA5A5A5A5;
        q.push_back('{d: 1, data: m_dload});
        @(posedge clk);
        #1 dwen = 0; dren = 0;
        access(0, 1, 32'h300, 2, 32'h0);
        // another read with fresh data
        dren = 1; daddr = 32'h104;
        m_dload = 32'hCAFE0001;
        q.push_back('{d: 1, data: m_dload});
        @(posedge clk);
        #1 dren = 0;
        access(1, 0, 32'h104, 2, 32'hCAFE0001);
        // watchdog on the TIMEOUT=4 instance
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        m_store = 0; m_dload = 0;
        @(negedge clk);
        check("to_rst_berr", 32'(s_berr), 0);
        s_en = 0; dren = 1; daddr = 32'h400;
        m_dload = 32'h55AA33CC;
        q.push_back('{d: 1, data: m_dload});
        @(posedge clk);
        #1 dren = 0;
        fork
            access(1, 0, 32'h400, 4, 32'h55AA33CC);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("to_ren_held", 32'(s_ren), 1);
                end
                @(negedge clk);
                check("to_ren_drop", 32'(s_ren), 0);
                check("to_berr", 32'(s_berr), 1);
                check("to_nohit", {30'b0, s_ihit, s_dhit}, 0);
                check("to_dload", s_dload, 0);
            end
        join
        check("to_nohit2", {30'b0, s_ihit, s_dhit}, 0);
        s_en = 1; ireq = 1; iaddr = 32'h80;
        q.push_back('{d: 0, data: 32'h0BADF00D});
        @(posedge clk);
        #1 ireq = 0;
        fork
            access(1, 0, 32'h80, 2, 32'h0BADF00D);
            begin
                repeat (2) begin
                    @(negedge clk);
                    check("to_next_ren", 32'(s_ren), 1);
                end
                @(negedge clk);
                check("to_next_ihit", 32'(s_ihit), 1);
                check("to_next_iload", s_iload, 32'h0BADF00D);
                check("to_berr_sticky", 32'(s_berr), 1);
            end
        join
        // reset in the middle of a read
        dren = 1; daddr = 32'h180;
        @(posedge clk);
        #1 dren = 0;
        @(negedge clk);
        check("mid_ren", 32'(ren), 1);
        rst = 1;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("mid_strobes", {30'b0, ren, wen}, 0);
        check("mid_hits", {30'b0, ihit, dhit}, 0);
        check("mid_berr", 32'(berr), 0);
        check("mid_s_berr", 32'(s_berr), 0);
        check("mid_s_ren", 32'(s_ren), 0);
        @(negedge clk);
        check("mid_nohit", {30'b0, ihit, dhit}, 0);
        repeat (2) @(negedge clk);
        check("sb_empty", 32'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
